uart_tx_frame: RTL



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx_frame.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit/receive blocks.
// The BREAK states exist only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    localparam int MIN_CPB = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK,
        BREAK_MARK
`endif
    } tx_state_e;

    // Code 3 is reserved and behaves as "no parity".
    function automatic parity_e decode_parity(input logic [1:0] code);
        case (code)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter: tick pulses in the last cycle of each period.
// Shared by the transmitter and the receiver.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] period,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] period_q;
    logic [DIV_WIDTH-1:0] cnt_q;

    // Load wins over enable so a new period can start in the same cycle the old one ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            period_q <= period;
            cnt_q    <= period - DIV_WIDTH'(1);
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_q <= period_q - DIV_WIDTH'(1);
            end else begin
                cnt_q <= cnt_q - DIV_WIDTH'(1);
            end
        end
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Run-time configurable UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, 1/2 stops.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_CPB = 87
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DIV_WIDTH-1:0]  cfg_cpb,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  serial_tx,
    output logic                  busy,
    output logic                  done
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                  break_req
`endif
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_second_q, stop_second_d;
    logic                  tx_q, tx_d;
    logic                  load, tick, tick_en;
    logic                  last_stop, accept;
    logic [DIV_WIDTH-1:0]  cpb_eff;
    parity_e               par_mode;

    assign cpb_eff  = (cfg_cpb < DIV_WIDTH'(MIN_CPB)) ? DIV_WIDTH'(DEFAULT_CPB) : cfg_cpb;
    assign par_mode = decode_parity(cfg_parity);
    assign tick_en  = (state_q != IDLE);

    uart_baud_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .en     (tick_en),
        .period (cpb_eff),
        .tick   (tick)
    );

    // Handshake: a word transfers on a rising edge with s_valid && s_ready. s_ready depends only
    // on registered state (IDLE, or the final cycle of the last stop bit), never on s_valid.
    assign last_stop = (state_q == STOP) && tick && (!stop2_q || stop_second_q);
    assign s_ready   = (state_q == IDLE) || last_stop;
    assign accept    = s_valid && s_ready;
    assign done      = last_stop;
    assign busy      = state_q inside {START, DATA, PARITY, STOP};
    assign serial_tx = tx_q;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        par_en_d      = par_en_q;
        par_bit_d     = par_bit_q;
        stop2_d       = stop2_q;
        stop_second_d = stop_second_q;
        load          = 1'b0;
        tx_d          = 1'b1;

        case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (!accept && break_req) state_d = BREAK;
`endif
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (last_stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    stop_second_d = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            // The mark after a break uses the live divisor, not a captured one.
            BREAK: begin
                if (!break_req) begin
                    state_d = BREAK_MARK;
                    load    = 1'b1;
                end
            end
            BREAK_MARK: begin
                if (tick) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d       = START;
            shift_d       = s_data;
            par_en_d      = (par_mode != PAR_NONE);
            par_bit_d     = (par_mode == PAR_ODD) ? ~^s_data : ^s_data;
            stop2_d       = cfg_stop2;
            stop_second_d = 1'b0;
            load          = 1'b1;
        end

        // The line value is decided for the state being entered, so it is registered, glitch-free.
        case (state_d)
            START:      tx_d = 1'b0;
            DATA:       tx_d = shift_d[0];
            PARITY:     tx_d = par_bit_q;
`ifdef UART_TX_BREAK_EN
            BREAK:      tx_d = 1'b0;
`endif
            default:    tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            idx_q         <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            stop2_q       <= 1'b0;
            stop_second_q <= 1'b0;
            tx_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            par_en_q      <= par_en_d;
            par_bit_q     <= par_bit_d;
            stop2_q       <= stop2_d;
            stop_second_q <= stop_second_d;
            tx_q          <= tx_d;
        end
    end

endmodule
